// File: rtl/tft_timing_gen_if.sv
// TFT raster bundle between the timing generator and its
// color source / panel pins.
interface tft_timing_gen_if;
  logic        ena;
  logic [23:0] color_in;
  logic [9:0]  tft_x;
  logic [8:0]  tft_y;
  logic        tft_new_frame;
  logic        tft_active;
  logic        tft_clk;
  logic        tft_hsync_n;
  logic        tft_vsync_n;
  logic        tft_de;
  logic [23:0] tft_rgb;
  logic        tft_disp;
  logic [15:0] frame_count;

  modport master (
    input  ena, color_in,
    output tft_x, tft_y, tft_new_frame, tft_active,
    output tft_clk, tft_hsync_n, tft_vsync_n, tft_de,
    output tft_rgb, tft_disp, frame_count
  );

  modport slave (
    output ena, color_in,
    input  tft_x, tft_y, tft_new_frame, tft_active,
    input  tft_clk, tft_hsync_n, tft_vsync_n, tft_de,
    input  tft_rgb, tft_disp, frame_count
  );
endinterface

// File: rtl/tft_timing_gen.sv
// TFT raster generator: pixel divider, scan counters, syncs,
// and color-latency alignment of DE/sync/RGB to the panel.
module tft_timing_gen #(
  parameter int CLK_DIV       = 4,
  parameter int H_ACTIVE      = 480,
  parameter int H_FRONT       = 2,
  parameter int H_SYNC        = 41,
  parameter int H_BACK        = 2,
  parameter int V_ACTIVE      = 272,
  parameter int V_FRONT       = 2,
  parameter int V_SYNC        = 10,
  parameter int V_BACK        = 2,
  parameter int COLOR_LATENCY = 1
) (
  input logic              clk,
  input logic              rstb,
  tft_timing_gen_if.master tft
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (COLOR_LATENCY > 0) ? COLOR_LATENCY : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [8:0] Y_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] Y_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] Y_VBL  = 9'(V_ACTIVE - 1);
  localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FRONT);
  localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } raw_t;

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [15:0]   fc_q, fc_d;
  logic          nf_q, nf_d;
  logic          pclk_q, pclk_d;
  logic          de_q, de_d;
  logic          hs_n_q, hs_n_d;
  logic          vs_n_q, vs_n_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          disp_q;
  raw_t [SW-1:0] sr_q, sr_d;

  logic tick;
  logic x_wrap;
  logic y_wrap;
  logic active;
  raw_t raw;
  raw_t dly;

  always_comb begin
    tick   = tft.ena && (div_q == DIV_LAST);
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    active = (x_q < X_ACT) && (y_q < Y_ACT);
    raw.de = active;
    raw.hs = (x_q >= HS_BEG) && (x_q < HS_END);
    raw.vs = (y_q >= VS_BEG) && (y_q < VS_END);
    dly    = (COLOR_LATENCY == 0) ? raw : sr_q[SW-1];
  end

  always_comb begin
    div_d  = div_q;
    x_d    = x_q;
    y_d    = y_q;
    fc_d   = fc_q;
    nf_d   = 1'b0;
    de_d   = de_q;
    hs_n_d = hs_n_q;
    vs_n_d = vs_n_q;
    rgb_d  = rgb_q;
    sr_d   = sr_q;
    pclk_d = (div_q >= DIV_HALF);
    if (!tft.ena) begin
      // Disabled: raster parked at origin, panel blanked.
      div_d  = '0;
      x_d    = '0;
      y_d    = '0;
      sr_d   = '0;
      de_d   = 1'b0;
      hs_n_d = 1'b1;
      vs_n_d = 1'b1;
      rgb_d  = '0;
    end else begin
      div_d = tick ? '0 : div_q + DW'(1);
      if (tick) begin
        x_d = x_wrap ? '0 : x_q + 10'd1;
        if (x_wrap) begin
          y_d = y_wrap ? '0 : y_q + 9'd1;
          if (y_wrap) fc_d = fc_q + 16'd1;
        end
        nf_d  = x_wrap && (y_q == Y_VBL);
        sr_d[0] = raw;
        for (int i = 1; i < SW; i++) sr_d[i] = sr_q[i-1];
        de_d   = dly.de;
        hs_n_d = ~dly.hs;
        vs_n_d = ~dly.vs;
        rgb_d  = dly.de ? tft.color_in : 24'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fc_q   <= '0;
      nf_q   <= 1'b0;
      pclk_q <= 1'b0;
      de_q   <= 1'b0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      rgb_q  <= '0;
      disp_q <= 1'b0;
      sr_q   <= '0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fc_q   <= fc_d;
      nf_q   <= nf_d;
      pclk_q <= pclk_d;
      de_q   <= de_d;
      hs_n_q <= hs_n_d;
      vs_n_q <= vs_n_d;
      rgb_q  <= rgb_d;
      disp_q <= tft.ena;
      sr_q   <= sr_d;
    end
  end

  assign tft.tft_x         = x_q;
  assign tft.tft_y         = y_q;
  assign tft.tft_new_frame = nf_q;
  assign tft.tft_active    = active;
  assign tft.tft_clk       = pclk_q;
  assign tft.tft_hsync_n   = hs_n_q;
  assign tft.tft_vsync_n   = vs_n_q;
  assign tft.tft_de        = de_q;
  assign tft.tft_rgb       = rgb_q;
  assign tft.tft_disp      = disp_q;
  assign tft.frame_count   = fc_q;

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen on a shrunken raster, with a
// modelled color source and an expected-output queue per pixel.
module tb_tft_timing_gen;

  localparam int CD  = 4;
  localparam int HA  = 20;
  localparam int HF  = 2;
  localparam int HS  = 5;
  localparam int HB  = 3;
  localparam int VA  = 12;
  localparam int VF  = 2;
  localparam int VS  = 3;
  localparam int VB  = 2;
  localparam int LAT = 2;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;

  typedef struct packed {
    logic        de;
    logic        hs_n;
    logic        vs_n;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rstb;

  tft_timing_gen_if bus();

  tft_timing_gen #(
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .COLOR_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rstb(rstb),
    .tft(bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  exp_t        expq[$];
  logic [23:0] cq[$];
  logic [9:0]  bx;
  logic [8:0]  by;
  logic [15:0] bfc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic restart_model();
    bx = '0;
    by = '0;
    expq.delete();
    cq.delete();
    for (int i = 0; i < LAT; i++) begin
      expq.push_back(exp_t'{1'b0, 1'b1, 1'b1, 24'h0});
      cq.push_back(24'h5A5A5A);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_x"}, 32'(bus.tft_x), 0);
    chk({tag, "_y"}, 32'(bus.tft_y), 0);
    chk({tag, "_de"}, 32'(bus.tft_de), 0);
    chk({tag, "_rgb"}, 32'(bus.tft_rgb), 0);
    chk({tag, "_hs_n"}, 32'(bus.tft_hsync_n), 1);
    chk({tag, "_vs_n"}, 32'(bus.tft_vsync_n), 1);
    chk({tag, "_nf"}, 32'(bus.tft_new_frame), 0);
    chk({tag, "_disp"}, 32'(bus.tft_disp), 0);
    chk({tag, "_fc"}, 32'(bus.frame_count), 0);
    chk({tag, "_pclk"}, 32'(bus.tft_clk), 0);
    chk({tag, "_active"}, 32'(bus.tft_active), 1);
  endtask

  task automatic pixel();
    logic        act;
    logic [23:0] col;
    logic        nf;
    int          highs;
    exp_t        e;
    act = (bx < HA) && (by < VA);
    chk("x", 32'(bus.tft_x), 32'(bx));
    chk("y", 32'(bus.tft_y), 32'(by));
    chk("active", 32'(bus.tft_active), 32'(act));
    col = {bx[7:0], by[7:0], 8'hA5};
    cq.push_back(col);
    bus.color_in = cq.pop_front();
    expq.push_back(exp_t'{
      act,
      !((bx >= HA + HF) && (bx < HA + HF + HS)),
      !((by >= VA + VF) && (by < VA + VF + VS)),
      act ? col : 24'h0});
    nf = (bx == 10'(HT - 1)) && (by == 9'(VA - 1));
    highs = 0;
    for (int k = 1; k <= CD; k++) begin
      @(posedge clk);
      #1;
      highs += int'(bus.tft_clk);
      if (k == CD) chk("new_frame", 32'(bus.tft_new_frame), 32'(nf));
      else chk("nf_idle", 32'(bus.tft_new_frame), 0);
      if (k == 1) chk("x_hold", 32'(bus.tft_x), 32'(bx));
    end
    chk("pclk_duty", 32'(highs), CD / 2);
    e = expq.pop_front();
    chk("de", 32'(bus.tft_de), 32'(e.de));
    chk("hsync_n", 32'(bus.tft_hsync_n), 32'(e.hs_n));
    chk("vsync_n", 32'(bus.tft_vsync_n), 32'(e.vs_n));
    chk("rgb", 32'(bus.tft_rgb), 32'(e.rgb));
    chk("disp", 32'(bus.tft_disp), 1);
    if (bx == 10'(HT - 1)) begin
      bx = '0;
      if (by == 9'(VT - 1)) begin
        by  = '0;
        bfc = bfc + 16'd1;
      end else begin
        by = by + 9'd1;
      end
    end else begin
      bx = bx + 10'd1;
    end
    chk("frame_count", 32'(bus.frame_count), 32'(bfc));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) pixel();
  endtask

  initial begin
    rstb = 1'b0;
    bus.ena = 1'b0;
    bus.color_in = '0;
    bfc = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");

    // Two full frames plus part of a line.
    rstb = 1'b1;
    bus.ena = 1'b1;
    restart_model();
    run(2 * HT * VT + 20);

    // Mid-frame reset, then resume from origin.
    run(8 * HT + 15 - 20);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    reset_checks("midrst");
    rstb = 1'b1;
    bfc = '0;
    restart_model();
    run(HT * VT + HT);

    // Display disabled for 1000 clocks mid-frame.
    bus.ena = 1'b0;
    @(posedge clk);
    #1;
    chk("off_disp", 32'(bus.tft_disp), 0);
    chk("off_de", 32'(bus.tft_de), 0);
    chk("off_rgb", 32'(bus.tft_rgb), 0);
    chk("off_hs_n", 32'(bus.tft_hsync_n), 1);
    chk("off_vs_n", 32'(bus.tft_vsync_n), 1);
    for (int i = 0; i < 10; i++) begin
      repeat (100) @(posedge clk);
      #1;
      chk("off_x", 32'(bus.tft_x), 0);
      chk("off_y", 32'(bus.tft_y), 0);
      chk("off_fc", 32'(bus.frame_count), 32'(bfc));
      chk("off_de", 32'(bus.tft_de), 0);
      chk("off_hs_n", 32'(bus.tft_hsync_n), 1);
      chk("off_vs_n", 32'(bus.tft_vsync_n), 1);
      chk("off_nf", 32'(bus.tft_new_frame), 0);
      chk("off_pclk", 32'(bus.tft_clk), 0);
      chk("off_disp", 32'(bus.tft_disp), 0);
    end
    bus.ena = 1'b1;
    restart_model();
    run(100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
